lsu_stage: RTL and testbench

Memory-access pipeline stage downstream of the execute stage. Accepts one instruction per handshake on the `valid_last`/`ready_last` interface and issues a load or store on a single-outstanding memory request/response bus. Loads are lane-aligned and sign/zero-extended; stores get byte strobes and replicated write data. Writeback information is presented to the writeback stage on `valid_next`/`ready_next`; non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_stage.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// lsu_stage: memory-access pipeline stage between execute and writeback.
//
// Accepts one instruction per valid_last/ready_last handshake and latches its payload.
// Memory instructions issue a single request on a one-outstanding request/response bus;
// loads have their lane extracted and sign/zero-extended, stores get byte strobes and
// lane-replicated write data. Non-memory instructions pass EX_result straight to wb_data
// with one cycle of latency. Results are offered downstream on valid_next/ready_next.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_last / ready_last    upstream handshake
//   pc, inst, rd, R_wen,
//   csr_wen, csrs              writeback payload carried through the stage
//   mem_ren, mem_wen, funct3   access type (load/store) and size/sign
//   EX_result                  effective address for memory ops, result otherwise
//   rs2_value                  store data
//   mem_req_*                  memory request channel (valid/ready handshake)
//   mem_resp_valid/rdata       memory response, always accepted, one per request
//   valid_next / ready_next    downstream handshake
//   *_next, wb_data            writeback payload presented downstream
module lsu_stage (
  input  logic        clk,
  input  logic        rst_n,
  // upstream
  input  logic        valid_last,
  output logic        ready_last,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [4:0]  rd,
  input  logic        R_wen,
  input  logic [3:0]  csr_wen,
  input  logic [31:0] csrs,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] EX_result,
  input  logic [31:0] rs2_value,
  // memory request
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  // memory response
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  // downstream
  output logic        valid_next,
  input  logic        ready_next,
  output logic [31:0] pc_next,
  output logic [31:0] inst_next,
  output logic [31:0] csrs_next,
  output logic [4:0]  rd_next,
  output logic        R_wen_next,
  output logic [3:0]  csr_wen_next,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  state_e      state_q;

  // Latched instruction payload
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] csrs_q;
  logic [4:0]  rd_q;
  logic        r_wen_q;
  logic [3:0]  csr_wen_q;
  logic        ren_q;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [31:0] ex_q;
  logic [31:0] rs2_q;
  logic [31:0] wb_q;

  logic        accept;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [3:0]  store_strb;
  logic [31:0] store_wdata;

  // A new instruction may enter while idle, or while the current result is leaving.
  assign ready_last = (state_q == StIdle) | ((state_q == StDone) & ready_next);
  assign accept     = valid_last & ready_last;

  assign lane = ex_q[1:0];

  // Load lane extraction from the response word.
  always_comb begin
    byte_sel  = mem_resp_rdata[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    load_data = mem_resp_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = mem_resp_rdata;
    endcase
  end

  // Store strobes and lane-replicated data; loads leave both at zero.
  always_comb begin
    store_strb  = 4'b0000;
    store_wdata = 32'h0000_0000;
    if (wen_q) begin
      case (funct3_q)
        3'b000: begin
          store_strb  = 4'b0001 << lane;
          store_wdata = {4{rs2_q[7:0]}};
        end
        3'b001: begin
          store_strb  = 4'b0011 << {lane[1], 1'b0};
          store_wdata = {2{rs2_q[15:0]}};
        end
        default: begin
          store_strb  = 4'b1111;
          store_wdata = rs2_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      inst_q    <= '0;
      csrs_q    <= '0;
      rd_q      <= '0;
      r_wen_q   <= 1'b0;
      csr_wen_q <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      funct3_q  <= '0;
      ex_q      <= '0;
      rs2_q     <= '0;
      wb_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            pc_q      <= pc;
            inst_q    <= inst;
            csrs_q    <= csrs;
            rd_q      <= rd;
            r_wen_q   <= R_wen;
            csr_wen_q <= csr_wen;
            ren_q     <= mem_ren;
            wen_q     <= mem_wen;
            funct3_q  <= funct3;
            ex_q      <= EX_result;
            rs2_q     <= rs2_value;
            if (mem_ren | mem_wen) begin
              state_q <= StReq;
            end else begin
              wb_q    <= EX_result;
              state_q <= StDone;
            end
          end else if ((state_q == StDone) && ready_next) begin
            state_q <= StIdle;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // Stores get the address back as their writeback value once acknowledged.
          if (mem_resp_valid) begin
            wb_q    <= wen_q ? ex_q : load_data;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs decode straight off the state register so that an
  // asynchronous reset drops them without waiting for a clock edge.
  assign mem_req_valid = (state_q == StReq);
  assign valid_next    = (state_q == StDone);

  assign mem_req_addr  = {ex_q[31:2], 2'b00};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = store_wdata;
  assign mem_req_wstrb = store_strb;

  assign pc_next      = pc_q;
  assign inst_next    = inst_q;
  assign csrs_next    = csrs_q;
  assign rd_next      = rd_q;
  assign R_wen_next   = r_wen_q;
  assign csr_wen_next = csr_wen_q;
  assign wb_data      = wb_q;

  // ren_q only matters through wen_q's complement; keep it for debug visibility.
  logic unused_ren;
  assign unused_ren = ren_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed, self-checking bench for lsu_stage. Writeback results are predicted into a
// scoreboard queue when an instruction is driven and compared when it leaves the stage.
module tb_lsu_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_last;
  logic        ready_last;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  rd;
  logic        R_wen;
  logic [3:0]  csr_wen;
  logic [31:0] csrs;
  logic        mem_ren;
  logic        mem_wen;
  logic [2:0]  funct3;
  logic [31:0] EX_result;
  logic [31:0] rs2_value;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        valid_next;
  logic        ready_next;
  logic [31:0] pc_next;
  logic [31:0] inst_next;
  logic [31:0] csrs_next;
  logic [4:0]  rd_next;
  logic        R_wen_next;
  logic [3:0]  csr_wen_next;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] csrs;
    logic [4:0]  rd;
    logic        rwen;
    logic [31:0] wb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  lsu_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_last    (valid_last),
    .ready_last    (ready_last),
    .pc            (pc),
    .inst          (inst),
    .rd            (rd),
    .R_wen         (R_wen),
    .csr_wen       (csr_wen),
    .csrs          (csrs),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .funct3        (funct3),
    .EX_result     (EX_result),
    .rs2_value     (rs2_value),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .valid_next    (valid_next),
    .ready_next    (ready_next),
    .pc_next       (pc_next),
    .inst_next     (inst_next),
    .csrs_next     (csrs_next),
    .rd_next       (rd_next),
    .R_wen_next    (R_wen_next),
    .csr_wen_next  (csr_wen_next),
    .wb_data       (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic [31:0] p, input logic [4:0] r, input logic ren,
                            input logic wen, input logic [2:0] f3, input logic [31:0] ex,
                            input logic [31:0] rs2);
    valid_last = 1'b1;
    pc         = p;
    inst       = p ^ 32'hA5A5_0013;
    rd         = r;
    R_wen      = ~wen;
    csr_wen    = p[5:2];
    csrs       = ~ex;
    mem_ren    = ren;
    mem_wen    = wen;
    funct3     = f3;
    EX_result  = ex;
    rs2_value  = rs2;
  endtask

  function automatic exp_t mk_exp(input logic [31:0] p, input logic [4:0] r, input logic wen,
                                  input logic [31:0] ex, input logic [31:0] wb);
    exp_t e;
    e.pc   = p;
    e.inst = p ^ 32'hA5A5_0013;
    e.csrs = ~ex;
    e.rd   = r;
    e.rwen = ~wen;
    e.wb   = wb;
    return e;
  endfunction

  // Wait (bounded) for ready_last, then let the accepting edge pass.
  task automatic accept_inst();
    int n = 0;
    #1;
    while (ready_last !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    check("ready_last_wait", {31'd0, ready_last}, 32'd1);
    cyc();
    valid_last = 1'b0;
  endtask

  task automatic do_mem(input logic [31:0] p, input logic [4:0] r, input logic ren,
                        input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input int stall);
    drive_inst(p, r, ren, wen, f3, addr, rs2);
    sb.push_back(mk_exp(p, r, wen, addr, exp_wb));
    accept_inst();
    check("req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("req_addr", mem_req_addr, {addr[31:2], 2'b00});
    check("req_wen", {31'd0, mem_req_wen}, {31'd0, wen});
    check("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, exp_strb});
    check("req_wdata", mem_req_wdata, exp_wdata);
    for (int i = 0; i < stall; i++) begin
      cyc();
      check("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("stall_req_addr", mem_req_addr, {addr[31:2], 2'b00});
      check("stall_req_wdata", mem_req_wdata, exp_wdata);
      check("stall_ready_last", {31'd0, ready_last}, 32'd0);
    end
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    check("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("wait_valid_next", {31'd0, valid_next}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    cyc();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    check("done_valid_next", {31'd0, valid_next}, 32'd1);
    check("done_wb_data", wb_data, exp_wb);
  endtask

  // Scoreboard side: every downstream handshake must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && valid_next && ready_next) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", pc_next, e.pc);
        check("sb_inst", inst_next, e.inst);
        check("sb_csrs", csrs_next, e.csrs);
        check("sb_rd", {27'd0, rd_next}, {27'd0, e.rd});
        check("sb_rwen", {31'd0, R_wen_next}, {31'd0, e.rwen});
        check("sb_csr_wen", {28'd0, csr_wen_next}, {28'd0, e.pc[5:2]});
        check("sb_wb", wb_data, e.wb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    valid_last     = 1'b0;
    pc             = '0;
    inst           = '0;
    rd             = '0;
    R_wen          = 1'b0;
    csr_wen        = '0;
    csrs           = '0;
    mem_ren        = 1'b0;
    mem_wen        = 1'b0;
    funct3         = '0;
    EX_result      = '0;
    rs2_value      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    ready_next     = 1'b1;

    #2;
    check("rst_ready_last", {31'd0, ready_last}, 32'd1);
    check("rst_valid_next", {31'd0, valid_next}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_rd_next", {27'd0, rd_next}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // ALU pass-through, one cycle latency
    drive_inst(32'h0000_0100, 5'd5, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
    sb.push_back(mk_exp(32'h0000_0100, 5'd5, 1'b0, 32'h0000_1234, 32'h0000_1234));
    accept_inst();
    check("alu_valid_next", {31'd0, valid_next}, 32'd1);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    check("alu_rd_next", {27'd0, rd_next}, 32'd5);
    check("alu_no_req", {31'd0, mem_req_valid}, 32'd0);

    // Loads and stores on a zero-wait bus
    do_mem(32'h200, 5'd6, 1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF,
           4'b0000, 32'h0, 32'hFFFF_FF80, 0);
    do_mem(32'h204, 5'd7, 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FFFF,
           4'b0000, 32'h0, 32'h0000_0080, 0);
    do_mem(32'h208, 5'd8, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0,
           4'b1100, 32'h1234_1234, 32'h0000_0102, 0);
    do_mem(32'h20C, 5'd9, 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF,
           4'b0000, 32'h0, 32'hFFFF_8001, 0);
    do_mem(32'h210, 5'd10, 1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'h0, 32'h8001_7FFF,
           4'b0000, 32'h0, 32'h0000_8001, 0);
    do_mem(32'h214, 5'd11, 1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0, 32'hDEAD_BEEF,
           4'b0000, 32'h0, 32'hDEAD_BEEF, 0);
    do_mem(32'h218, 5'd12, 1'b1, 1'b0, 3'b011, 32'h0000_0007, 32'h0, 32'hCAFE_F00D,
           4'b0000, 32'h0, 32'hCAFE_F00D, 0);
    do_mem(32'h21C, 5'd13, 1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h1234_56EF, 32'h0,
           4'b0010, 32'hEFEF_EFEF, 32'h0000_0011, 0);
    do_mem(32'h220, 5'd14, 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h0BAD_F00D, 32'h0,
           4'b1111, 32'h0BAD_F00D, 32'h0000_0040, 0);
    cyc();
    check("idle_after_mem", {31'd0, valid_next}, 32'd0);

    // Backpressure on both the request and the downstream side
    ready_next = 1'b0;
    do_mem(32'h300, 5'd15, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h5555_AAAA,
           4'b0000, 32'h0, 32'h5555_AAAA, 3);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("bp_valid_next", {31'd0, valid_next}, 32'd1);
      check("bp_wb_data", wb_data, 32'h5555_AAAA);
      check("bp_pc_next", pc_next, 32'h300);
      check("bp_rd_next", {27'd0, rd_next}, 32'd15);
      check("bp_ready_last", {31'd0, ready_last}, 32'd0);
    end
    ready_next = 1'b1;
    cyc();
    check("bp_released", {31'd0, valid_next}, 32'd0);

    // Back-to-back pass-through, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive_inst(32'h400 + 32'(4 * i), 5'(16 + i), 1'b0, 1'b0, 3'b000,
                 32'h1000 + 32'(i), 32'h0);
      sb.push_back(mk_exp(32'h400 + 32'(4 * i), 5'(16 + i), 1'b0, 32'h1000 + 32'(i),
                          32'h1000 + 32'(i)));
      #1;
      check("b2b_ready_last", {31'd0, ready_last}, 32'd1);
      cyc();
      check("b2b_valid_next", {31'd0, valid_next}, 32'd1);
      check("b2b_wb_data", wb_data, 32'h1000 + 32'(i));
    end
    valid_last = 1'b0;
    cyc();
    check("b2b_drained", {31'd0, valid_next}, 32'd0);

    // Async reset while a result is held in DONE
    ready_next = 1'b0;
    drive_inst(32'h500, 5'd20, 1'b0, 1'b0, 3'b000, 32'h7777_7777, 32'h0);
    accept_inst();
    check("rd_done_valid", {31'd0, valid_next}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_valid_drop", {31'd0, valid_next}, 32'd0);
    check("rd_ready_last", {31'd0, ready_last}, 32'd1);
    check("rd_wb_clear", wb_data, 32'd0);
    cyc();
    rst_n      = 1'b1;
    ready_next = 1'b1;
    cyc();

    // Async reset while the request is pending
    drive_inst(32'h600, 5'd21, 1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
    accept_inst();
    check("rr_req_valid", {31'd0, mem_req_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_req_drop", {31'd0, mem_req_valid}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Async reset in WAIT, then a stale response
    drive_inst(32'h700, 5'd22, 1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0);
    accept_inst();
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    check("rw_in_wait", {31'd0, mem_req_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rw_valid_next", {31'd0, valid_next}, 32'd0);
    check("rw_ready_last", {31'd0, ready_last}, 32'd1);
    cyc();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1357_9BDF;
    cyc();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_no_valid", {31'd0, valid_next}, 32'd0);
      check("rw_wb_untouched", wb_data, 32'd0);
      cyc();
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
